// File: rtl/ol_rx_deframer.sv
// Receive deframer: finds SOF-delimited fixed-length frames, verifies the
// 16-bit additive checksum and releases only verified payload through a FIFO.
module ol_rx_deframer #(
   parameter int          PAYLOAD_LEN = 8,
   parameter int          FIFO_AW     = 5,
   parameter logic [15:0] SOF_WORD    = 16'hA55A
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        link_up,
   input  logic [15:0] rx_data,
   input  logic [1:0]  rx_datak,
   output logic [15:0] m_data,
   output logic        m_valid,
   output logic        m_last,
   input  logic        m_ready,
   output logic [15:0] frame_ok_cnt,
   output logic [15:0] csum_err_cnt,
   output logic [15:0] fmt_err_cnt,
   output logic [15:0] drop_cnt
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int CW    = $clog2(PAYLOAD_LEN + 2);

   typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, DISCARD} state_t;

   state_t             state, next_state;
   logic [FIFO_AW:0]   wr_ptr, commit_ptr, rd_ptr;
   logic [16:0]        mem [DEPTH];
   logic [15:0]        sum;
   logic [CW-1:0]      cnt;
   logic [FIFO_AW+1:0] used, free;
   logic               sof_hit, abort, room, last_word, pop;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Free space is judged against the read pointer as it stood before this edge.
   assign used      = {1'b0, wr_ptr - rd_ptr};
   assign free      = (FIFO_AW+2)'(DEPTH) - used;
   assign room      = free >= (FIFO_AW+2)'(PAYLOAD_LEN);
   assign sof_hit   = link_up && (rx_datak == 2'b00) && (rx_data == SOF_WORD);
   assign abort     = (rx_datak != 2'b00) || !link_up;
   assign last_word = (cnt == CW'(PAYLOAD_LEN - 1));
   assign pop       = m_valid && m_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (sof_hit) next_state = room ? PAYLOAD : DISCARD;
         PAYLOAD: if (abort) next_state = IDLE;
                  else if (last_word) next_state = CHECK;
         CHECK:   next_state = IDLE;
         DISCARD: if (!link_up || cnt == CW'(PAYLOAD_LEN)) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      m_valid           = (rd_ptr != commit_ptr);
      {m_last, m_data}  = mem[rd_ptr[FIFO_AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (state == PAYLOAD && !abort)
         mem[wr_ptr[FIFO_AW-1:0]] <= {last_word, rx_data};
   end

   // Pointer and counter datapath; rollback simply rewinds wr_ptr to commit_ptr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr       <= '0;
         commit_ptr   <= '0;
         rd_ptr       <= '0;
         sum          <= '0;
         cnt          <= '0;
         frame_ok_cnt <= '0;
         csum_err_cnt <= '0;
         fmt_err_cnt  <= '0;
         drop_cnt     <= '0;
      end else begin
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case (state)
            IDLE: begin
               if (sof_hit) begin
                  sum <= '0;
                  cnt <= '0;
                  if (!room) drop_cnt <= sat_inc(drop_cnt);
               end
            end
            PAYLOAD: begin
               if (abort) begin
                  wr_ptr      <= commit_ptr;
                  fmt_err_cnt <= sat_inc(fmt_err_cnt);
               end else begin
                  wr_ptr <= wr_ptr + 1'b1;
                  sum    <= sum + rx_data;
                  cnt    <= cnt + 1'b1;
               end
            end
            CHECK: begin
               if (abort) begin
                  wr_ptr      <= commit_ptr;
                  fmt_err_cnt <= sat_inc(fmt_err_cnt);
               end else if (rx_data == sum) begin
                  commit_ptr   <= wr_ptr;
                  frame_ok_cnt <= sat_inc(frame_ok_cnt);
               end else begin
                  wr_ptr       <= commit_ptr;
                  csum_err_cnt <= sat_inc(csum_err_cnt);
               end
            end
            DISCARD: cnt <= cnt + 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ol_rx_deframer.sv
// Scoreboard bench for ol_rx_deframer: committed frames are queued when sent
// and compared word by word as the FIFO releases them.
module tb_ol_rx_deframer;

   localparam int          PAYLOAD_LEN = 8;
   localparam logic [15:0] SOF         = 16'hA55A;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        link_up;
   logic [15:0] rx_data;
   logic [1:0]  rx_datak;
   logic [15:0] m_data;
   logic        m_valid;
   logic        m_last;
   logic        m_ready;
   logic [15:0] frame_ok_cnt, csum_err_cnt, fmt_err_cnt, drop_cnt;

   logic [16:0] exp_q[$];
   logic [15:0] payload [PAYLOAD_LEN];
   int vec_count  = 0;
   int miss_count = 0;
   int exp_ok = 0, exp_csum = 0, exp_fmt = 0, exp_drop = 0;

   ol_rx_deframer #(.PAYLOAD_LEN(PAYLOAD_LEN), .FIFO_AW(5), .SOF_WORD(SOF)) dut (
      .clk(clk), .rst_n(rst_n), .link_up(link_up), .rx_data(rx_data),
      .rx_datak(rx_datak), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
      .m_ready(m_ready), .frame_ok_cnt(frame_ok_cnt), .csum_err_cnt(csum_err_cnt),
      .fmt_err_cnt(fmt_err_cnt), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vec_count++;
      if (observed !== expected) begin
         miss_count++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] d, input logic [1:0] k, input logic lu);
      @(posedge clk);
      #1;
      rx_data  = d;
      rx_datak = k;
      link_up  = lu;
   endtask

   task automatic sendIdle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(16'h50BC, 2'b01, 1'b1);
   endtask

   function automatic logic [15:0] payloadSum();
      logic [15:0] s = 16'h0;
      for (int i = 0; i < PAYLOAD_LEN; i++) s = s + payload[i];
      return s;
   endfunction

   task automatic fillSeq(input logic [15:0] start);
      for (int i = 0; i < PAYLOAD_LEN; i++) payload[i] = start + 16'(i);
   endtask

   // Sends SOF, payload and checksum; queues the payload when a commit is expected.
   task automatic sendFrame(input logic [15:0] csum, input bit commit);
      if (commit)
         for (int i = 0; i < PAYLOAD_LEN; i++)
            exp_q.push_back({(i == PAYLOAD_LEN - 1), payload[i]});
      applyStimulus(SOF, 2'b00, 1'b1);
      for (int i = 0; i < PAYLOAD_LEN; i++) applyStimulus(payload[i], 2'b00, 1'b1);
      applyStimulus(csum, 2'b00, 1'b1);
   endtask

   task automatic waitDrain();
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
      checkOutput("drain", exp_q.size(), 0);
   endtask

   task automatic checkCounters(input string tag);
      @(negedge clk);
      checkOutput({tag, "_ok"},   frame_ok_cnt, exp_ok);
      checkOutput({tag, "_csum"}, csum_err_cnt, exp_csum);
      checkOutput({tag, "_fmt"},  fmt_err_cnt,  exp_fmt);
      checkOutput({tag, "_drop"}, drop_cnt,     exp_drop);
   endtask

   always @(negedge clk) begin
      if (rst_n && m_valid && m_ready) begin
         if (exp_q.size() == 0) checkOutput("spurious_word", 32'(m_valid), 0);
         else checkOutput("word", {m_last, m_data}, exp_q.pop_front());
      end
   end

   initial begin
      rst_n    = 1'b0;
      link_up  = 1'b1;
      rx_data  = 16'h50BC;
      rx_datak = 2'b01;
      m_ready  = 1'b1;
      #1;
      checkOutput("reset_valid", m_valid, 0);
      checkOutput("reset_last", m_last, 0);
      checkOutput("reset_ok", frame_ok_cnt, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      sendIdle(2);

      // 1: good frame, first word visible the cycle after the checksum edge
      fillSeq(16'd1);
      sendFrame(16'h0024, 1'b1);
      @(negedge clk);
      checkOutput("valid_before_csum_edge", m_valid, 0);
      @(negedge clk);
      checkOutput("valid_after_csum_edge", m_valid, 1);
      exp_ok++;
      sendIdle(1);
      waitDrain();
      checkCounters("t1");

      // 2: bad checksum is rolled back
      sendFrame(16'h0025, 1'b0);
      exp_csum++;
      sendIdle(4);
      checkOutput("t2_no_output", m_valid, 0);
      checkCounters("t2");

      // 3: checksum wraps modulo 2^16
      for (int i = 0; i < PAYLOAD_LEN; i++) payload[i] = 16'hFFFF;
      checkOutput("t3_model_sum", payloadSum(), 16'hFFF8);
      sendFrame(16'hFFF8, 1'b1);
      exp_ok++;
      sendIdle(1);
      waitDrain();
      checkCounters("t3");

      // 4: k-word inside payload aborts, next frame intact
      applyStimulus(SOF, 2'b00, 1'b1);
      for (int i = 1; i <= 3; i++) applyStimulus(16'(i), 2'b00, 1'b1);
      applyStimulus(16'h50BC, 2'b11, 1'b1);
      exp_fmt++;
      sendIdle(4);
      checkOutput("t4_no_output", m_valid, 0);
      fillSeq(16'h0010);
      sendFrame(payloadSum(), 1'b1);
      exp_ok++;
      sendIdle(1);
      waitDrain();
      checkCounters("t4");

      // 5: fill the FIFO, then two frames dropped back to back
      m_ready = 1'b0;
      for (int f = 1; f <= 4; f++) begin
         fillSeq(16'(f * 256));
         sendFrame(payloadSum(), 1'b1);
         exp_ok++;
      end
      for (int i = 0; i < PAYLOAD_LEN; i++) payload[i] = SOF;
      sendFrame(payloadSum(), 1'b0);
      fillSeq(16'h0500);
      sendFrame(payloadSum(), 1'b0);
      exp_drop += 2;
      sendIdle(2);
      checkOutput("t5_full_valid", m_valid, 1);
      checkCounters("t5");
      m_ready = 1'b1;
      waitDrain();
      fillSeq(16'h0600);
      sendFrame(payloadSum(), 1'b1);
      exp_ok++;
      sendIdle(1);
      waitDrain();
      checkCounters("t5b");

      // 6: link loss mid-payload, then recovery
      applyStimulus(SOF, 2'b00, 1'b1);
      for (int i = 1; i <= 3; i++) applyStimulus(16'(i), 2'b00, 1'b1);
      applyStimulus(16'd4, 2'b00, 1'b0);
      exp_fmt++;
      sendIdle(2);
      fillSeq(16'h0700);
      sendFrame(payloadSum(), 1'b1);
      exp_ok++;
      sendIdle(1);
      waitDrain();
      checkCounters("t6");

      // Reset mid-frame with committed data still queued
      m_ready = 1'b0;
      fillSeq(16'h0800);
      sendFrame(payloadSum(), 1'b1);
      applyStimulus(SOF, 2'b00, 1'b1);
      applyStimulus(16'd1, 2'b00, 1'b1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      exp_ok = 0; exp_csum = 0; exp_fmt = 0; exp_drop = 0;
      checkOutput("rst_mid_valid", m_valid, 0);
      checkOutput("rst_mid_last", m_last, 0);
      checkOutput("rst_mid_ok", frame_ok_cnt, 0);
      checkOutput("rst_mid_fmt", fmt_err_cnt, 0);
      checkOutput("rst_mid_drop", drop_cnt, 0);
      repeat (2) @(negedge clk);
      rst_n   = 1'b1;
      m_ready = 1'b1;
      sendIdle(2);
      fillSeq(16'h0900);
      sendFrame(payloadSum(), 1'b1);
      exp_ok++;
      sendIdle(1);
      waitDrain();
      checkCounters("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
      $finish;
   end

endmodule
